oc_tick_scheduler: RTL and testbench
====================================

Name: oc_tick_scheduler

Overview:
Periodic event scheduler driven by the chip-status timebase pulses (tick1us/tick1ms/tick1s). It gives NumChannels requesters (e.g. housekeeping, sensor polling, watchdog kick) each an independent programmable period. All channels share one registered event output with a valid/ready handshake, arbitrated round-robin. It sits beside oc_chip_status and feeds timed work requests to the management/CSR logic.

Parameters:
NumChannels, 4, number of independent periodic channels (2..16)
PeriodWidth, 16, width of each channel period/counter
ChannelWidth, $clog2(NumChannels), localparam, width of event channel ID

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
tick1us  input  1  one-cycle pulse every 1us (chipStatus.tick1us)
tick1ms  input  1  one-cycle pulse every 1ms (chipStatus.tick1ms)
tick1s  input  1  one-cycle pulse every 1s (chipStatus.tick1s)
cfgEnable  input  NumChannels  per-channel enable
cfgUnit  input  2*NumChannels  per-channel tick unit: 0=us, 1=ms, 2=s, 3=every clock
cfgPeriod  input  PeriodWidth*NumChannels  per-channel period in units; 0 = channel inactive
eventValid  output  1  event available
eventChannel  output  ChannelWidth  channel ID of presented event
eventReady  input  1  consumer accepts event
overrun  output  NumChannels  sticky: channel fired while its previous event still pending
overrunClear  input  NumChannels  one-cycle pulse clears matching overrun bit

Behaviour:
- Reset: synchronous, active-high. Counters=0, pending=0, eventValid=0, eventChannel=0, overrun=0, RR pointer=0 (channel 0 highest priority first). Reset mid-operation discards pending and presented events; eventValid=0 after the reset edge.
- Active channel: cfgEnable=1 and cfgPeriod!=0. Inactive channel: counter held 0, pending bit cleared, no fires.
- Selected tick per channel = tick1us/tick1ms/tick1s/1'b1 per cfgUnit.
- Counter: on a selected tick, if count >= cfgPeriod-1, count<=0 and the channel fires; otherwise count<=count+1. Use >= so that shrinking cfgPeriod on the fly fires on the next tick rather than wrapping. Fire spacing is exactly cfgPeriod ticks.
- Fire sets pending[ch] at the same edge (pending visible 1 cycle after the tick cycle).
- Fire while pending[ch] already 1 and not consumed this cycle: overrun[ch]<=1; the events coalesce (pending stays 1, single event).
- Fire in the same cycle pending[ch] is loaded into the output register: pending[ch] stays 1, no overrun.
- Output register loads when !eventValid || eventReady. It selects the first pending channel at or after the RR pointer (wrapping modulo NumChannels), clears that pending bit, sets eventValid=1 and eventChannel=ch, and sets RR pointer=ch+1 (wrap). No pending channel: eventValid<=0.
- Latency: tick at cycle T -> pending at T+1 -> eventValid at T+2 if output idle.
- Handshake: eventChannel is stable while eventValid && !eventReady; transfer occurs when eventValid && eventReady. Back-to-back events are supported at 1 per cycle.
- Disabling a channel whose event is already in the output register does not retract it; the event is delivered.
- overrun: set has priority over overrunClear in the same cycle. It is cleared only by overrunClear or reset.

Test Plan:
- Ch0 unit=3, period=4, eventReady=1 constant, others disabled -> eventValid one cycle every 4 cycles, eventChannel=0, first event 2 cycles after the first tick, overrun=0.
- Real tick source at 156.25 MHz; ch1 unit=0 period=1000 -> 20 consecutive events spaced 1.000 ms ±2 clock periods; ch2 unit=1 period=3 -> events spaced 3 ms.
- All 4 channels unit=3 period=1, eventReady=1 -> eventChannel sequence 0,1,2,3,0,1,... with no gaps; overrun=4'b1111 within 4 cycles.
- Ch2 unit=3 period=3, eventReady=0 for 20 cycles -> eventValid=1 with eventChannel=2 held stable, overrun[2]=1. Pulse overrunClear[2] -> 0 (and re-sets on the next fire). Raise eventReady -> a pending ch2 event follows the accepted one.
- 3 channels pending and eventValid=1, assert reset for 1 cycle -> eventValid=0, overrun=0 after the edge. After release the first event occurs only after the full period is re-counted.
- Ch3 pending, then set cfgPeriod[3]=0 before grant -> no ch3 event. Restore period=5 -> events resume every 5 ticks from count 0.

Source files
------------

// File: rtl/oc_tick_scheduler.sv
// oc_tick_scheduler: per-channel programmable periodic events, round-robin onto one valid/ready output
module oc_tick_scheduler #(
  parameter int NumChannels = 4,
  parameter int PeriodWidth = 16,
  localparam int ChannelWidth = $clog2(NumChannels)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               tick1us,
  input  logic                               tick1ms,
  input  logic                               tick1s,
  input  logic [NumChannels-1:0]             cfgEnable,
  input  logic [2*NumChannels-1:0]           cfgUnit,
  input  logic [PeriodWidth*NumChannels-1:0] cfgPeriod,
  output logic                               eventValid,
  output logic [ChannelWidth-1:0]            eventChannel,
  input  logic                               eventReady,
  output logic [NumChannels-1:0]             overrun,
  input  logic [NumChannels-1:0]             overrunClear
);
  logic [PeriodWidth-1:0]  r_count [NumChannels];
  logic [PeriodWidth-1:0]  w_per [NumChannels];
  logic [ChannelWidth-1:0] w_idx [NumChannels];
  logic [NumChannels-1:0]  r_pending, r_overrun, w_active, w_tick, w_fire, w_clr;
  logic [ChannelWidth-1:0] r_chan, r_ptr, w_sel;
  logic                    r_valid, w_found, w_load;
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      w_per[c] = cfgPeriod[c*PeriodWidth +: PeriodWidth];
      w_active[c] = cfgEnable[c] && (w_per[c] != '0);
      w_tick[c] = cfgUnit[2*c +: 2] == 2'd0 ? tick1us :
                  cfgUnit[2*c +: 2] == 2'd1 ? tick1ms :
                  cfgUnit[2*c +: 2] == 2'd2 ? tick1s : 1'b1;
      w_fire[c] = w_active[c] && w_tick[c] && (r_count[c] >= w_per[c] - PeriodWidth'(1));
    end
  end
  // Scan from the highest offset down so the pending channel nearest the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_sel = '0;
    for (int i = 0; i < NumChannels; i++)
      w_idx[i] = ChannelWidth'((int'(r_ptr) + i) % NumChannels);
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (r_pending[w_idx[i]]) begin
        w_found = 1'b1;
        w_sel = w_idx[i];
      end
    end
  end
  assign w_load = !r_valid || eventReady;
  assign w_clr = (w_load && w_found) ? (NumChannels'(1) << w_sel) : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NumChannels; c++) r_count[c] <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_valid <= 1'b0;
      r_chan <= '0;
      r_ptr <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++)
        r_count[c] <= !w_active[c] ? '0 : !w_tick[c] ? r_count[c] :
                      w_fire[c] ? '0 : r_count[c] + PeriodWidth'(1);
      r_pending <= ((r_pending & ~w_clr) | w_fire) & w_active;
      r_overrun <= (r_overrun & ~overrunClear) | (w_fire & r_pending & ~w_clr);
      if (w_load) begin
        r_valid <= w_found;
        if (w_found) begin
          r_chan <= w_sel;
          r_ptr <= (w_sel == ChannelWidth'(NumChannels - 1)) ? '0 : w_sel + ChannelWidth'(1);
        end
      end
    end
  end
  assign eventValid = r_valid;
  assign eventChannel = r_chan;
  assign overrun = r_overrun;
endmodule

// File: tb/tb_oc_tick_scheduler.sv
// tb_oc_tick_scheduler: directed checks of period timing, round-robin, handshake, overrun and reset
module tb_oc_tick_scheduler;
  logic        clock = 1'b0;
  logic        reset, tick1us, tick1ms, tick1s, eventReady, eventValid;
  logic [3:0]  cfgEnable, overrun, overrunClear;
  logic [7:0]  cfgUnit;
  logic [63:0] cfgPeriod;
  logic [1:0]  eventChannel;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  bit          tick_en = 0;
  logic [15:0] vec, seq;
  int          nv, stable;
  int          last [4], cnt [4], mn [4], mx [4];
  oc_tick_scheduler #(.NumChannels(4), .PeriodWidth(16)) dut (
    .clock(clock), .reset(reset), .tick1us(tick1us), .tick1ms(tick1ms), .tick1s(tick1s),
    .cfgEnable(cfgEnable), .cfgUnit(cfgUnit), .cfgPeriod(cfgPeriod),
    .eventValid(eventValid), .eventChannel(eventChannel), .eventReady(eventReady),
    .overrun(overrun), .overrunClear(overrunClear)
  );
  initial forever #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Scaled timebase: 1us = 5 clocks, 1ms = 10us, 1s = 10ms.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    tick1us = tick_en && (cyc % 5 == 0);
    tick1ms = tick_en && (cyc % 50 == 0);
    tick1s  = tick_en && (cyc % 500 == 0);
  endtask
  task automatic set_ch(input int c, input logic en, input logic [1:0] u, input logic [15:0] p);
    cfgEnable[c] = en;
    cfgUnit[2*c +: 2] = u;
    cfgPeriod[16*c +: 16] = p;
  endtask
  task automatic do_reset();
    cfgEnable = '0; cfgUnit = '0; cfgPeriod = '0;
    eventReady = 0; overrunClear = '0;
    reset = 1;
    step();
    reset = 0;
  endtask
  initial begin
    tick1us = 0; tick1ms = 0; tick1s = 0;
    do_reset();
    reset = 1;
    step();
    chk("rst_valid", 32'(eventValid), 0);
    chk("rst_chan", 32'(eventChannel), 0);
    chk("rst_ovr", 32'(overrun), 0);
    reset = 0;
    set_ch(0, 1, 3, 4);
    eventReady = 1;
    vec = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      vec[i] = eventValid;
      if (eventValid) chk("t1_chan", 32'(eventChannel), 0);
    end
    chk("t1_pattern", 32'(vec), 32'h1110);
    chk("t1_ovr", 32'(overrun), 0);
    do_reset();
    set_ch(1, 1, 0, 10);
    set_ch(2, 1, 1, 3);
    eventReady = 1;
    tick_en = 1;
    for (int c = 0; c < 4; c++) begin last[c] = -1; cnt[c] = 0; mn[c] = 99999; mx[c] = 0; end
    for (int i = 0; i < 700; i++) begin
      step();
      if (eventValid) begin
        if (last[eventChannel] >= 0) begin
          if (i - last[eventChannel] < mn[eventChannel]) mn[eventChannel] = i - last[eventChannel];
          if (i - last[eventChannel] > mx[eventChannel]) mx[eventChannel] = i - last[eventChannel];
        end
        last[eventChannel] = i;
        cnt[eventChannel]++;
      end
    end
    tick_en = 0;
    chk("t2_ch1_cnt", 32'(cnt[1] >= 10), 1);
    chk("t2_ch1_spacing", 32'(mn[1] >= 48 && mx[1] <= 52), 1);
    chk("t2_ch2_cnt", 32'(cnt[2] >= 3), 1);
    chk("t2_ch2_spacing", 32'(mn[2] >= 148 && mx[2] <= 152), 1);
    chk("t2_idle_chans", 32'(cnt[0] + cnt[3]), 0);
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 1, 3, 1);
    eventReady = 1;
    step();
    chk("t3_first_idle", 32'(eventValid), 0);
    seq = '0; nv = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      nv += int'(eventValid);
      seq = {seq[13:0], eventChannel};
      if (i == 1) chk("t3_ovr_early", 32'(overrun), 32'hF);
    end
    chk("t3_valid_cnt", 32'(nv), 8);
    chk("t3_seq", 32'(seq), 32'h1B1B);
    do_reset();
    set_ch(2, 1, 3, 3);
    stable = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i >= 4 && (!eventValid || eventChannel != 2'd2)) stable = 0;
    end
    chk("t4_hold", 32'(stable), 1);
    chk("t4_ovr", 32'(overrun), 32'h4);
    step();
    overrunClear = 4'h4;
    step();
    overrunClear = '0;
    chk("t4_clr", 32'(overrun), 0);
    step();
    step();
    chk("t4_reset_ovr", 32'(overrun), 32'h4);
    eventReady = 1;
    step();
    chk("t4_next_valid", 32'(eventValid), 1);
    chk("t4_next_chan", 32'(eventChannel), 2);
    step();
    chk("t4_drain", 32'(eventValid), 0);
    do_reset();
    for (int c = 0; c < 3; c++) set_ch(c, 1, 3, 3);
    for (int i = 0; i < 8; i++) step();
    chk("t5_pre_valid", 32'(eventValid), 1);
    chk("t5_pre_ovr", 32'(overrun), 32'h6);
    reset = 1;
    step();
    chk("t5_rst_valid", 32'(eventValid), 0);
    chk("t5_rst_ovr", 32'(overrun), 0);
    reset = 0;
    vec = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      vec[i] = eventValid;
    end
    chk("t5_recount", 32'(vec[3:0]), 32'h8);
    chk("t5_chan", 32'(eventChannel), 0);
    do_reset();
    set_ch(0, 1, 3, 1);
    set_ch(3, 1, 3, 2);
    step();
    step();
    chk("t6_busy_valid", 32'(eventValid), 1);
    chk("t6_busy_chan", 32'(eventChannel), 0);
    cfgPeriod[63:48] = '0;
    cfgEnable[0] = 0;
    step();
    eventReady = 1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      nv += int'(eventValid);
    end
    chk("t6_no_ch3", 32'(nv), 0);
    cfgPeriod[63:48] = 16'd5;
    vec = '0;
    for (int i = 0; i < 11; i++) begin
      step();
      vec[i] = eventValid;
      if (eventValid) chk("t6_chan", 32'(eventChannel), 3);
    end
    chk("t6_resume", 32'(vec[10:0]), 32'h420);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
